// File: rtl/local_bus_master.sv
// Single-transaction master for an asynchronous strobe/acknowledge slave bus.
// Sequence: address/data setup, strobe until ack, wait for ack release, done.
module local_bus_master #(
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        SYSCLK,
  input  logic        RST_N,
  input  logic        REQ,
  input  logic        WR,
  input  logic [4:0]  ADDR,
  input  logic [31:0] WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic        FRS,
  output logic        FWS,
  output logic [4:0]  FA,
  input  logic        FDTACK,
  output logic [31:0] DATA_OUT,
  output logic        DATA_OE,
  input  logic [31:0] DATA_IN
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  sync_q;
  logic        dtack_s;
  logic        wr_q, wr_d;
  logic [4:0]  fa_q, fa_d;
  logic [31:0] dout_q, dout_d;
  logic [31:0] rdata_q, rdata_d;
  logic        oe_q, oe_d;
  logic        frs_q, frs_d;
  logic        fws_q, fws_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  // Synchronizer resets to the idle (released) ack level.
  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], FDTACK};
  end
  assign dtack_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    fa_d    = fa_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    oe_d    = oe_q;
    frs_d   = frs_q;
    fws_d   = fws_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A request coinciding with DONE is dropped, not deferred.
        if (REQ && !done_q) begin
          state_d = SETUP;
          cnt_d   = '0;
          wr_d    = WR;
          fa_d    = ADDR;
          dout_d  = WDATA;
          oe_d    = WR;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = STROBE;
          cnt_d   = '0;
          frs_d   = !wr_q;
          fws_d   = wr_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STROBE: begin
        if (!dtack_s) begin
          state_d = RELEASE;
          cnt_d   = '0;
          frs_d   = 1'b0;
          fws_d   = 1'b0;
          if (!wr_q) rdata_d = DATA_IN;
        end else if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          frs_d   = 1'b0;
          fws_d   = 1'b0;
          oe_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RELEASE: begin
        if (dtack_s) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          done_d  = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // BUSY covers the DONE cycle, which is already spent in IDLE.
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      fa_q    <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      oe_q    <= 1'b0;
      frs_q   <= 1'b0;
      fws_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      fa_q    <= fa_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      oe_q    <= oe_d;
      frs_q   <= frs_d;
      fws_q   <= fws_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign RDATA    = rdata_q;
  assign FRS      = frs_q;
  assign FWS      = fws_q;
  assign FA       = fa_q;
  assign DATA_OUT = dout_q;
  assign DATA_OE  = oe_q;

endmodule
